ex_mem_stage: RTL and testbench

- Pipeline boundary directly downstream of the execute-stage ALU. Registers the ALU result, its overflow flag and the instruction's memory/writeback control toward the memory stage.
- Uses a valid/ready handshake with a two-entry skid buffer, so back-pressure from memory never creates a combinational path to execute.
- Traps on signed overflow: squashes the offending instruction's side effects and latches a sticky exception record for the control unit.

---
 rtl/ex_mem_stage.sv | 111 +++++++++++
 tb/tb_ex_mem_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ex_mem_stage: EX->MEM pipeline boundary with a two-entry skid buffer and a
// sticky signed-overflow exception record.
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_overflow,
  input  logic          trap_en,
  input  logic [31:0]   pc,
  input  logic [RW-1:0] rd,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [DW-1:0] store_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [DW-1:0] out_store_data,
  output logic [31:0]   out_pc,
  output logic [RW-1:0] out_rd,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write,
  output logic          exc_valid,
  output logic [31:0]   exc_pc,
  input  logic          exc_clear
);

  // Entry layout: {result, store_data, pc, rd, reg_write, mem_read, mem_write}
  localparam int EW = 2*DW + 32 + RW + 3;

  logic          r_main_valid;
  logic          r_skid_valid;
  logic [EW-1:0] r_main;
  logic [EW-1:0] r_skid;
  logic          r_exc_valid;
  logic [31:0]   r_exc_pc;

  logic          w_accept;
  logic          w_trap;
  logic          w_main_free;
  logic [EW-1:0] w_in_entry;

  // in_ready depends only on state registers, so out_ready never reaches execute.
  assign in_ready    = ~r_skid_valid & ~r_exc_valid;
  assign w_accept    = in_valid & in_ready & ~flush;
  assign w_trap      = w_accept & alu_overflow & trap_en & ~r_exc_valid;
  assign w_main_free = ~r_main_valid | out_ready;
  assign w_in_entry  = {alu_result, store_data, pc, rd,
                        reg_write & ~w_trap, mem_read & ~w_trap, mem_write & ~w_trap};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main[2:0]  <= 3'b000;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_in_entry;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
        r_main[2:0]  <= 3'b000;
      end
    end else if (w_accept) begin
      r_skid       <= w_in_entry;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc_valid <= 1'b0;
      r_exc_pc    <= '0;
    end else if (w_trap) begin
      r_exc_valid <= 1'b1;
      r_exc_pc    <= pc;
    end else if (exc_clear) begin
      r_exc_valid <= 1'b0;
    end
  end

  assign out_valid      = r_main_valid;
  assign out_result     = r_main[EW-1 -: DW];
  assign out_store_data = r_main[EW-DW-1 -: DW];
  assign out_pc         = r_main[RW+3+31 -: 32];
  assign out_rd         = r_main[RW+2:3];
  assign out_reg_write  = r_main[2];
  assign out_mem_read   = r_main[1];
  assign out_mem_write  = r_main[0];
  assign exc_valid      = r_exc_valid;
  assign exc_pc         = r_exc_pc;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// tb_ex_mem_stage: directed checks of streaming, back-pressure, trap, flush and async reset.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_result, pc, store_data;
  logic        alu_overflow, trap_en;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data, out_pc;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        exc_valid, exc_clear;
  logic [31:0] exc_pc;

  int n_checks = 0;
  int n_fails  = 0;

  ex_mem_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .trap_en(trap_en),
    .pc(pc), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .store_data(store_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_pc(out_pc), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .exc_valid(exc_valid), .exc_pc(exc_pc),
    .exc_clear(exc_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 0; alu_result = 0; pc = 0; store_data = 0;
    alu_overflow = 0; trap_en = 0; rd = 0; reg_write = 0; mem_read = 0;
    mem_write = 0; flush = 0; out_ready = 1; exc_clear = 0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_exc_valid", {31'b0, exc_valid}, 32'h0);
    chk("rst_exc_pc", exc_pc, 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_rw", {31'b0, out_reg_write}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Streaming
    in_valid = 1; reg_write = 1; rd = 3; pc = 32'h10; alu_result = 32'h1;
    step();
    chk("s1_valid", {31'b0, out_valid}, 32'h1);
    chk("s1_result", out_result, 32'h1);
    chk("s1_rw", {31'b0, out_reg_write}, 32'h1);
    chk("s1_in_ready", {31'b0, in_ready}, 32'h1);
    alu_result = 32'h2; step();
    chk("s2_result", out_result, 32'h2);
    chk("s2_in_ready", {31'b0, in_ready}, 32'h1);
    alu_result = 32'h3; step();
    chk("s3_result", out_result, 32'h3);
    chk("s3_rd", {27'b0, out_rd}, 32'h3);
    in_valid = 0; step();
    chk("s_drain_valid", {31'b0, out_valid}, 32'h0);

    // Back-pressure
    out_ready = 0; in_valid = 1; alu_result = 32'hA; step();
    chk("bp_a_result", out_result, 32'hA);
    chk("bp_a_in_ready", {31'b0, in_ready}, 32'h1);
    alu_result = 32'hB; step();
    chk("bp_b_result", out_result, 32'hA);
    chk("bp_b_in_ready", {31'b0, in_ready}, 32'h0);
    in_valid = 0; step();
    chk("bp_hold_result", out_result, 32'hA);
    chk("bp_hold_in_ready", {31'b0, in_ready}, 32'h0);
    out_ready = 1; step();
    chk("bp_emit_b_valid", {31'b0, out_valid}, 32'h1);
    chk("bp_emit_b_result", out_result, 32'hB);
    chk("bp_emit_b_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp_empty_valid", {31'b0, out_valid}, 32'h0);

    // Non-trapping overflow
    in_valid = 1; alu_overflow = 1; trap_en = 0; reg_write = 1; alu_result = 32'h5;
    step();
    chk("nt_rw", {31'b0, out_reg_write}, 32'h1);
    chk("nt_exc_valid", {31'b0, exc_valid}, 32'h0);
    in_valid = 0; alu_overflow = 0; step();

    // Overflow trap: 0x7FFFFFFF + 1
    in_valid = 1; alu_result = 32'h8000_0000; alu_overflow = 1; trap_en = 1;
    pc = 32'h40; rd = 5; reg_write = 1; mem_write = 1; store_data = 32'h77;
    step();
    chk("tr_valid", {31'b0, out_valid}, 32'h1);
    chk("tr_rw", {31'b0, out_reg_write}, 32'h0);
    chk("tr_mw", {31'b0, out_mem_write}, 32'h0);
    chk("tr_pc", out_pc, 32'h40);
    chk("tr_rd", {27'b0, out_rd}, 32'h5);
    chk("tr_result", out_result, 32'h8000_0000);
    chk("tr_exc_valid", {31'b0, exc_valid}, 32'h1);
    chk("tr_exc_pc", exc_pc, 32'h40);
    chk("tr_in_ready", {31'b0, in_ready}, 32'h0);
    alu_overflow = 0; trap_en = 0; mem_write = 0; alu_result = 32'h99; pc = 32'h44;
    step();
    chk("tr_blocked_valid", {31'b0, out_valid}, 32'h0);
    chk("tr_blocked_in_ready", {31'b0, in_ready}, 32'h0);
    chk("tr_sticky", {31'b0, exc_valid}, 32'h1);
    exc_clear = 1; step();
    chk("clr_exc_valid", {31'b0, exc_valid}, 32'h0);
    chk("clr_in_ready", {31'b0, in_ready}, 32'h1);
    chk("clr_exc_pc", exc_pc, 32'h40);
    chk("clr_no_accept", {31'b0, out_valid}, 32'h0);
    exc_clear = 0; in_valid = 0; step();

    // Flush while full
    out_ready = 0; in_valid = 1; alu_result = 32'h11; step();
    alu_result = 32'h22; step();
    chk("fl_full_in_ready", {31'b0, in_ready}, 32'h0);
    flush = 1; alu_result = 32'h33; step();
    chk("fl_valid", {31'b0, out_valid}, 32'h0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'h1);
    chk("fl_rw", {31'b0, out_reg_write}, 32'h0);
    flush = 0; in_valid = 0; out_ready = 1; step();
    chk("fl_no_emit1", {31'b0, out_valid}, 32'h0);
    step();
    chk("fl_no_emit2", {31'b0, out_valid}, 32'h0);

    // Async reset mid-stream with exception pending
    out_ready = 0; in_valid = 1; alu_result = 32'h123; alu_overflow = 1; trap_en = 1;
    pc = 32'h80; rd = 7; step();
    chk("ar_pre_valid", {31'b0, out_valid}, 32'h1);
    chk("ar_pre_exc", {31'b0, exc_valid}, 32'h1);
    in_valid = 0; alu_overflow = 0; trap_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'h0);
    chk("ar_exc_valid", {31'b0, exc_valid}, 32'h0);
    chk("ar_exc_pc", exc_pc, 32'h0);
    chk("ar_out_pc", out_pc, 32'h0);
    chk("ar_out_result", out_result, 32'h0);
    chk("ar_out_rd", {27'b0, out_rd}, 32'h0);
    chk("ar_out_rw", {31'b0, out_reg_write}, 32'h0);
    #10 rst_n = 1'b1;
    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
`default_nettype wire
